// File: rtl/time_counter.sv
// Time-of-day counter: prescaled 1 s tick, h:m:s counters with carries, binary and BCD views.
// Latency: counters update one edge after the sampled input; BCD is combinational from the registers.
module time_counter #(
    parameter int TICKS_PER_SEC = 32768,
    parameter int PRE_W         = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       secs,
    input  logic       mins,
    input  logic       hours,
    output logic [5:0] sec_cnt,
    output logic [5:0] min_cnt,
    output logic [4:0] hour_cnt,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       sec_tick,
    output logic       day_tick
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hour_q, hour_d;
    logic             sec_tick_q, sec_tick_d;
    logic             day_tick_q, day_tick_d;

    logic sec_top, min_top, hour_top;

    // ">=" rather than "==" so any out-of-range value still wraps to 0.
    assign sec_top  = (sec_q  >= 6'd59);
    assign min_top  = (min_q  >= 6'd59);
    assign hour_top = (hour_q >= 5'd23);

    always_comb begin
        pre_d      = '0;
        sec_d      = '0;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        if (secs) begin
            if (pre_q >= PRE_MAX) begin
                sec_tick_d = 1'b1;
                if (sec_top) begin
                    if (min_top) begin
                        min_d = '0;
                        if (hour_top) begin
                            hour_d     = '0;
                            day_tick_d = 1'b1;
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
                sec_d = sec_q;
            end
        end else begin
            // Set mode: independent increments, no carry between fields.
            if (mins) begin
                min_d = min_top ? 6'd0 : min_q + 6'd1;
            end
            if (hours) begin
                hour_d = hour_top ? 5'd0 : hour_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    // Tens found by a fixed compare/subtract ladder; inputs never exceed 59.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        if (rem >= 6'd50) begin
            tens = 4'd5;
            rem  = rem - 6'd50;
        end else if (rem >= 6'd40) begin
            tens = 4'd4;
            rem  = rem - 6'd40;
        end else if (rem >= 6'd30) begin
            tens = 4'd3;
            rem  = rem - 6'd30;
        end else if (rem >= 6'd20) begin
            tens = 4'd2;
            rem  = rem - 6'd20;
        end else if (rem >= 6'd10) begin
            tens = 4'd1;
            rem  = rem - 6'd10;
        end
        return {tens, 4'(rem)};
    endfunction

    assign sec_cnt  = sec_q;
    assign min_cnt  = min_q;
    assign hour_cnt = hour_q;
    assign sec_bcd  = to_bcd(sec_q);
    assign min_bcd  = to_bcd(min_q);
    assign hour_bcd = to_bcd({1'b0, hour_q});
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;

endmodule
